// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared constants and helpers for the mux_scan block.
//  Revision    : 1.0  initial release
// ============================================================================
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Width of an index/counter covering 0..n-1, never narrower than 1 bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : mux_pkg
`default_nettype wire

// File: rtl/mux_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_if
//  Description : Output handshake of mux_scan (sample, channel tag, valid,
//                ready). master = producer side, slave = consumer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface mux_scan_if
    import mux_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 1
);
    localparam int SW = idx_width(N);

    logic [W-1:0]  y;
    logic          y_valid;
    logic [SW-1:0] y_chan;
    logic          out_ready;

    modport master (output y, output y_valid, output y_chan, input  out_ready);
    modport slave  (input  y, input  y_valid, input  y_chan, output out_ready);

endinterface : mux_scan_if
`default_nettype wire

// File: rtl/mux_scan_next.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_next
//  Description : Rotating priority finder: first enabled channel strictly
//                after ptr, searching cyclically upward. Returns ptr itself
//                when it is the only enabled channel.
//  Revision    : 1.0  initial release
// ============================================================================
module mux_scan_next
    import mux_pkg::*;
#(
    parameter int N  = 8,
    parameter int SW = idx_width(N)
) (
    input  wire logic [N-1:0]  chan_en,
    input  wire logic [SW-1:0] ptr,
    output logic      [SW-1:0] nxt,
    output logic               any
);

    // Scan offsets from farthest to nearest so the nearest enabled one wins.
    always_comb begin
        logic [SW:0] idx;
        nxt = '0;
        idx = '0;
        for (int i = N; i >= 1; i--) begin
            idx = {1'b0, ptr} + (SW+1)'(i);
            if (idx >= (SW+1)'(N)) begin
                idx = idx - (SW+1)'(N);
            end
            if (chan_en[idx[SW-1:0]]) begin
                nxt = idx[SW-1:0];
            end
        end
    end

    assign any = |chan_en;

endmodule : mux_scan_next
`default_nettype wire

// File: rtl/mux_scan.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan
//  Description : N-channel, W-bit registered multiplexer with direct select
//                and round-robin scan modes, driving a one-entry
//                valid/ready output slice.
//  Revision    : 1.0  initial release
// ============================================================================
module mux_scan
    import mux_pkg::*;
#(
    parameter int N     = 8,
    parameter int W     = 1,
    parameter int DWELL = 1
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    input  wire logic [N*W-1:0]  d,
    input  wire logic [idx_width(N)-1:0] s,
    input  wire logic            mode,
    input  wire logic [N-1:0]    chan_en,
    input  wire logic            hold,
    mux_scan_if.master           bus
);

    localparam int SW = idx_width(N);
    localparam int DW = idx_width(DWELL);

    logic [W-1:0]  chans [N];
    logic [SW-1:0] ptr;
    logic [DW-1:0] dwell_cnt;
    logic [SW-1:0] sel_direct;
    logic [SW-1:0] sel;
    logic          src_ok;
    logic          load;
    logic [SW-1:0] nxt;
    logic          any;

    // Unflatten the channel bus into an indexable array.
    for (genvar k = 0; k < N; k++) begin : g_chan
        assign chans[k] = d[k*W +: W];
    end

    // Out-of-range external selects fall back to channel 0.
    assign sel_direct = ({1'b0, s} >= (SW+1)'(N)) ? '0 : s;
    assign sel        = (mode == MODE_SCAN) ? ptr : sel_direct;
    assign src_ok     = (mode == MODE_SCAN) ? chan_en[ptr] : 1'b1;
    assign load       = (!bus.y_valid || bus.out_ready) && src_ok;

    mux_scan_next #(.N(N), .SW(SW)) u_next (
        .chan_en (chan_en),
        .ptr     (ptr),
        .nxt     (nxt),
        .any     (any)
    );

    // Output slice: load a fresh sample when free, drop valid when drained
    // with nothing to replace it, otherwise hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.y       <= '0;
            bus.y_valid <= 1'b0;
            bus.y_chan  <= '0;
        end else if (load) begin
            bus.y       <= chans[sel];
            bus.y_valid <= 1'b1;
            bus.y_chan  <= sel;
        end else if (bus.y_valid && bus.out_ready) begin
            bus.y_valid <= 1'b0;
        end
    end

    // Scan pointer and dwell counter; direct mode keeps the pointer tracking
    // the external select so a later scan resumes from there.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            dwell_cnt <= '0;
        end else if (mode == MODE_DIRECT) begin
            ptr       <= sel_direct;
            dwell_cnt <= '0;
        end else if (hold) begin
            ptr       <= ptr;
            dwell_cnt <= dwell_cnt;
        end else if (!chan_en[ptr]) begin
            if (any) begin
                ptr       <= nxt;
                dwell_cnt <= '0;
            end
        end else if (load) begin
            if (dwell_cnt == DW'(DWELL - 1)) begin
                dwell_cnt <= '0;
                ptr       <= nxt;
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
        end
    end

endmodule : mux_scan
`default_nettype wire

// File: tb/tb_mux_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_scan
//  Description : Directed self-checking bench for mux_scan (N=8/DWELL=2 and
//                N=6/DWELL=1 instances sharing clock and reset).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mux_scan;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] d8;
    logic [2:0]  s8;
    logic        mode8;
    logic [7:0]  en8;
    logic        hold8;
    logic [23:0] d6;
    logic [2:0]  s6;

    int total = 0;
    int bad   = 0;

    mux_scan_if #(.N(8), .W(4)) bus8 ();
    mux_scan_if #(.N(6), .W(4)) bus6 ();

    mux_scan #(.N(8), .W(4), .DWELL(2)) dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (d8),
        .s       (s8),
        .mode    (mode8),
        .chan_en (en8),
        .hold    (hold8),
        .bus     (bus8)
    );

    mux_scan #(.N(6), .W(4), .DWELL(1)) dut6 (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (d6),
        .s       (s6),
        .mode    (1'b0),
        .chan_en (6'h3F),
        .hold    (1'b0),
        .bus     (bus6)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check all three outputs of the N=8 instance.
    task automatic chk8(input string tag, input int v, input int ch, input int val);
        chk({tag, ".valid"}, 32'(bus8.y_valid), 32'(v));
        chk({tag, ".chan"},  32'(bus8.y_chan),  32'(ch));
        chk({tag, ".y"},     32'(bus8.y),       32'(val));
    endtask

    initial begin
        int exp_ch [8];
        reset_n = 1'b0;
        d8      = {4'd10, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3};
        d6      = {4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3};
        s8      = 3'd0;
        s6      = 3'd7;
        mode8   = 1'b0;
        en8     = 8'hFF;
        hold8   = 1'b0;
        bus8.out_ready = 1'b1;
        bus6.out_ready = 1'b1;

        tick();
        tick();
        chk8("rst", 0, 0, 0);
        chk("rst6.valid", 32'(bus6.y_valid), 32'd0);
        reset_n = 1'b1;

        // Direct mode sweep; N=6 instance sees out-of-range 7, then 5.
        for (int i = 0; i < 8; i++) begin
            s8 = 3'(i);
            s6 = (i < 4) ? 3'd7 : 3'd5;
            tick();
            chk8($sformatf("dir%0d", i), 1, i, i + 3);
            chk($sformatf("dir6_%0d.chan", i), 32'(bus6.y_chan), (i < 4) ? 32'd0 : 32'd5);
            chk($sformatf("dir6_%0d.y", i),    32'(bus6.y),      (i < 4) ? 32'd3 : 32'd8);
        end

        // Park pointer on 0, then scan all channels with dwell 2.
        s8 = 3'd0;
        tick();
        mode8 = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            chk8($sformatf("scan%0d", i), 1, (i / 2) % 8, ((i / 2) % 8) + 3);
        end

        // Sparse enables, starting from a disabled channel (1): one idle cycle.
        mode8 = 1'b0;
        s8    = 3'd1;
        tick();
        mode8 = 1'b1;
        en8   = 8'b1000_0101;
        tick();
        chk("skip.valid", 32'(bus8.y_valid), 32'd0);
        exp_ch = '{2, 2, 7, 7, 0, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            tick();
            chk8($sformatf("sparse%0d", i), 1, exp_ch[i], exp_ch[i] + 3);
        end

        // Backpressure: ptr=2, dwell=0, y holds channel 0.
        en8 = 8'hFF;
        bus8.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk8($sformatf("stall%0d", i), 1, 0, 3);
        end
        bus8.out_ready = 1'b1;
        tick();
        chk8("resume0", 1, 2, 5);
        tick();
        chk8("resume1", 1, 2, 5);

        // Hold for 3 cycles on channel 3, then its normal dwell, then 4.
        hold8  = 1'b1;
        exp_ch = '{3, 3, 3, 3, 3, 4, 0, 0};
        for (int i = 0; i < 6; i++) begin
            if (i == 3) hold8 = 1'b0;
            tick();
            chk8($sformatf("hold%0d", i), 1, exp_ch[i], exp_ch[i] + 3);
        end

        // All channels disabled: valid drops and stays low, tag holds.
        en8 = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("noen%0d.valid", i), 32'(bus8.y_valid), 32'd0);
            chk($sformatf("noen%0d.chan", i),  32'(bus8.y_chan),  32'd4);
        end
        en8 = 8'hFF;
        tick();
        chk8("reen", 1, 4, 7);

        // Asynchronous reset between edges.
        #3;
        reset_n = 1'b0;
        #1;
        chk8("arst", 0, 0, 0);
        tick();
        tick();
        reset_n = 1'b1;
        exp_ch = '{0, 0, 1, 1, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            tick();
            chk8($sformatf("restart%0d", i), 1, exp_ch[i], exp_ch[i] + 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mux_scan
`default_nettype wire
